// File: rtl/control_unit.sv
// Microcoded control unit for an 8-bit bus computer: instruction register, step
// counter, flags and halt latch, with a combinational control word.
module control_unit #(
    parameter int STEPS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bus_in,
    input  logic       cf_in,
    input  logic       zf_in,
    output logic [3:0] ir_operand,
    output logic       HLT,
    output logic       MI,
    output logic       RI,
    output logic       RO,
    output logic       IO,
    output logic       II,
    output logic       AI,
    output logic       AO,
    output logic       EO,
    output logic       SU,
    output logic       BI,
    output logic       OI,
    output logic       CE,
    output logic       CO,
    output logic       J,
    output logic       FI,
    output logic [2:0] step,
    output logic       carry_flag,
    output logic       zero_flag
);

    localparam int B_HLT = 15, B_MI = 14, B_RI = 13, B_RO = 12, B_IO = 11, B_II = 10;
    localparam int B_AI = 9, B_AO = 8, B_EO = 7, B_SU = 6, B_BI = 5, B_OI = 4;
    localparam int B_CE = 3, B_CO = 2, B_J = 1, B_FI = 0;
    localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

    logic [7:0]  ir_q, ir_d;
    logic [2:0]  step_q, step_d;
    logic        carry_q, carry_d, zero_q, zero_d;
    logic        halted_q, halted_d;
    logic [15:0] cw;

    always_comb begin
        cw = '0;
        if (halted_q) begin
            cw[B_HLT] = 1'b1;
        end else if (step_q == 3'd0) begin
            cw[B_CO] = 1'b1;
            cw[B_MI] = 1'b1;
        end else if (step_q == 3'd1) begin
            cw[B_RO] = 1'b1;
            cw[B_II] = 1'b1;
            cw[B_CE] = 1'b1;
        end else begin
            case (ir_q[7:4])
                4'h1: case (step_q)
                    3'd2:    begin cw[B_IO] = 1'b1; cw[B_MI] = 1'b1; end
                    3'd3:    begin cw[B_RO] = 1'b1; cw[B_AI] = 1'b1; end
                    default: ;
                endcase
                4'h2, 4'h3: case (step_q)
                    3'd2:    begin cw[B_IO] = 1'b1; cw[B_MI] = 1'b1; end
                    3'd3:    begin cw[B_RO] = 1'b1; cw[B_BI] = 1'b1; end
                    3'd4: begin
                        cw[B_EO] = 1'b1;
                        cw[B_AI] = 1'b1;
                        cw[B_FI] = 1'b1;
                        cw[B_SU] = (ir_q[7:4] == 4'h3);
                    end
                    default: ;
                endcase
                4'h4: case (step_q)
                    3'd2:    begin cw[B_IO] = 1'b1; cw[B_MI] = 1'b1; end
                    3'd3:    begin cw[B_AO] = 1'b1; cw[B_RI] = 1'b1; end
                    default: ;
                endcase
                4'h5: if (step_q == 3'd2) begin cw[B_IO] = 1'b1; cw[B_AI] = 1'b1; end
                4'h6: if (step_q == 3'd2) begin cw[B_IO] = 1'b1; cw[B_J] = 1'b1; end
                // Conditional jumps still spend T2 on IO when the flag is clear
                4'h7: if (step_q == 3'd2) begin cw[B_IO] = 1'b1; cw[B_J] = carry_q; end
                4'h8: if (step_q == 3'd2) begin cw[B_IO] = 1'b1; cw[B_J] = zero_q; end
                4'hE: if (step_q == 3'd2) begin cw[B_AO] = 1'b1; cw[B_OI] = 1'b1; end
                4'hF: if (step_q == 3'd2) cw[B_HLT] = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        ir_d     = cw[B_II] ? bus_in : ir_q;
        carry_d  = cw[B_FI] ? cf_in : carry_q;
        zero_d   = cw[B_FI] ? zf_in : zero_q;
        halted_d = halted_q | cw[B_HLT];
        // HLT freezes the counter on the very edge that sets the halt latch
        if (cw[B_HLT])
            step_d = step_q;
        else if (step_q >= LAST_STEP || (step_q >= 3'd2 && cw == '0))
            step_d = 3'd0;
        else
            step_d = step_q + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q     <= 8'h00;
            step_q   <= 3'd0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            step_q   <= step_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            halted_q <= halted_d;
        end
    end

    assign {HLT, MI, RI, RO, IO, II, AI, AO, EO, SU, BI, OI, CE, CO, J, FI} = cw;
    assign ir_operand = ir_q[3:0];
    assign step       = step_q;
    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver queues the expected outputs of
// each cycle, the monitor pops and compares on the falling edge.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] bus_in = 8'h00;
    logic       cf_in = 1'b0, zf_in = 1'b0;
    logic [3:0] ir_operand;
    logic       HLT, MI, RI, RO, IO, II, AI, AO, EO, SU, BI, OI, CE, CO, J, FI;
    logic [2:0] step;
    logic       carry_flag, zero_flag;

    control_unit #(.STEPS(5)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .cf_in(cf_in), .zf_in(zf_in),
        .ir_operand(ir_operand),
        .HLT(HLT), .MI(MI), .RI(RI), .RO(RO), .IO(IO), .II(II), .AI(AI), .AO(AO),
        .EO(EO), .SU(SU), .BI(BI), .OI(OI), .CE(CE), .CO(CO), .J(J), .FI(FI),
        .step(step), .carry_flag(carry_flag), .zero_flag(zero_flag)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] C_HLT = 16'h8000, C_MI = 16'h4000, C_RI = 16'h2000, C_RO = 16'h1000;
    localparam logic [15:0] C_IO  = 16'h0800, C_II = 16'h0400, C_AI = 16'h0200, C_AO = 16'h0100;
    localparam logic [15:0] C_EO  = 16'h0080, C_SU = 16'h0040, C_BI = 16'h0020, C_OI = 16'h0010;
    localparam logic [15:0] C_CE  = 16'h0008, C_CO = 16'h0004, C_J  = 16'h0002, C_FI = 16'h0001;
    localparam logic [15:0] FETCH0 = C_CO | C_MI;
    localparam logic [15:0] FETCH1 = C_RO | C_II | C_CE;

    typedef struct {
        logic [15:0] cw;
        logic [2:0]  st;
        logic [3:0]  op;
        logic        fc;
        logic        fz;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [15:0] act_cw;
    assign act_cw = {HLT, MI, RI, RO, IO, II, AI, AO, EO, SU, BI, OI, CE, CO, J, FI};

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (act_cw !== e.cw || step !== e.st || ir_operand !== e.op ||
                carry_flag !== e.fc || zero_flag !== e.fz) begin
                errors++;
                $display("FAIL %s: got cw=%h step=%0d op=%h c=%b z=%b, want cw=%h step=%0d op=%h c=%b z=%b",
                         e.name, act_cw, step, ir_operand, carry_flag, zero_flag,
                         e.cw, e.st, e.op, e.fc, e.fz);
            end
        end
    end

    // One clock: drive this cycle's inputs, queue the outputs the current state must show.
    task automatic cyc(input logic r, input logic [7:0] b, input logic c, input logic z,
                       input logic [15:0] cw, input logic [2:0] st, input logic [3:0] op,
                       input logic fc, input logic fz, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; bus_in = b; cf_in = c; zf_in = z;
        e.cw = cw; e.st = st; e.op = op; e.fc = fc; e.fz = fz; e.name = nm;
        sb_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);

        cyc(0, 8'h00, 0, 0, FETCH0,        0, 4'h0, 0, 0, "reset_idle");
        // LDA 0xE
        cyc(0, 8'h1E, 0, 0, FETCH1,        1, 4'h0, 0, 0, "lda_t1");
        cyc(0, 8'h00, 1, 1, C_IO | C_MI,   2, 4'hE, 0, 0, "lda_t2");
        cyc(0, 8'h00, 1, 1, C_RO | C_AI,   3, 4'hE, 0, 0, "lda_t3");
        cyc(0, 8'h00, 1, 1, 16'h0,         4, 4'hE, 0, 0, "lda_t4");
        // ADD with carry out
        cyc(0, 8'h00, 0, 0, FETCH0,        0, 4'hE, 0, 0, "add_t0");
        cyc(0, 8'h25, 0, 0, FETCH1,        1, 4'hE, 0, 0, "add_t1");
        cyc(0, 8'h00, 0, 0, C_IO | C_MI,   2, 4'h5, 0, 0, "add_t2");
        cyc(0, 8'h00, 0, 0, C_RO | C_BI,   3, 4'h5, 0, 0, "add_t3");
        cyc(0, 8'h00, 1, 0, C_EO | C_AI | C_FI, 4, 4'h5, 0, 0, "add_t4");
        cyc(0, 8'h00, 0, 1, FETCH0,        0, 4'h5, 1, 0, "add_flags");
        // JC taken, JZ not taken
        cyc(0, 8'h73, 0, 0, FETCH1,        1, 4'h5, 1, 0, "jc_t1");
        cyc(0, 8'h00, 0, 0, C_IO | C_J,    2, 4'h3, 1, 0, "jc_taken");
        cyc(0, 8'h00, 0, 0, 16'h0,         3, 4'h3, 1, 0, "jc_t3");
        cyc(0, 8'h00, 0, 0, FETCH0,        0, 4'h3, 1, 0, "jc_end");
        cyc(0, 8'h84, 0, 0, FETCH1,        1, 4'h3, 1, 0, "jz_t1");
        cyc(0, 8'h00, 0, 0, C_IO,          2, 4'h4, 1, 0, "jz_not_taken");
        cyc(0, 8'h00, 0, 0, 16'h0,         3, 4'h4, 1, 0, "jz_t3");
        cyc(0, 8'h00, 0, 0, FETCH0,        0, 4'h4, 1, 0, "jz_early_end");
        // SUB setting zero flag, then JZ taken
        cyc(0, 8'h3A, 0, 0, FETCH1,        1, 4'h4, 1, 0, "sub_t1");
        cyc(0, 8'h00, 0, 0, C_IO | C_MI,   2, 4'hA, 1, 0, "sub_t2");
        cyc(0, 8'h00, 0, 0, C_RO | C_BI,   3, 4'hA, 1, 0, "sub_t3");
        cyc(0, 8'h00, 0, 1, C_EO | C_AI | C_SU | C_FI, 4, 4'hA, 1, 0, "sub_t4");
        cyc(0, 8'h00, 1, 1, FETCH0,        0, 4'hA, 0, 1, "sub_flags");
        cyc(0, 8'h85, 1, 1, FETCH1,        1, 4'hA, 0, 1, "jz2_t1");
        cyc(0, 8'h00, 1, 1, C_IO | C_J,    2, 4'h5, 0, 1, "jz_taken");
        cyc(0, 8'h00, 1, 1, 16'h0,         3, 4'h5, 0, 1, "jz2_t3");
        cyc(0, 8'h00, 0, 0, FETCH0,        0, 4'h5, 0, 1, "jz2_end");
        // Unused opcode 0xB: three cycles total
        cyc(0, 8'hB0, 0, 0, FETCH1,        1, 4'h5, 0, 1, "nopb_t1");
        cyc(0, 8'h00, 0, 0, 16'h0,         2, 4'h0, 0, 1, "nopb_t2");
        cyc(0, 8'h00, 0, 0, FETCH0,        0, 4'h0, 0, 1, "nopb_done");
        // OUT
        cyc(0, 8'hE0, 0, 0, FETCH1,        1, 4'h0, 0, 1, "out_t1");
        cyc(0, 8'h00, 0, 0, C_AO | C_OI,   2, 4'h0, 0, 1, "out_t2");
        cyc(0, 8'h00, 0, 0, 16'h0,         3, 4'h0, 0, 1, "out_t3");
        cyc(0, 8'h00, 0, 0, FETCH0,        0, 4'h0, 0, 1, "out_end");
        // STA
        cyc(0, 8'h4C, 0, 0, FETCH1,        1, 4'h0, 0, 1, "sta_t1");
        cyc(0, 8'h00, 0, 0, C_IO | C_MI,   2, 4'hC, 0, 1, "sta_t2");
        cyc(0, 8'h00, 0, 0, C_AO | C_RI,   3, 4'hC, 0, 1, "sta_t3");
        cyc(0, 8'h00, 0, 0, 16'h0,         4, 4'hC, 0, 1, "sta_t4");
        cyc(0, 8'h00, 0, 0, FETCH0,        0, 4'hC, 0, 1, "sta_end");
        // LDI
        cyc(0, 8'h57, 0, 0, FETCH1,        1, 4'hC, 0, 1, "ldi_t1");
        cyc(0, 8'h00, 0, 0, C_IO | C_AI,   2, 4'h7, 0, 1, "ldi_t2");
        cyc(0, 8'h00, 0, 0, 16'h0,         3, 4'h7, 0, 1, "ldi_t3");
        cyc(0, 8'h00, 0, 0, FETCH0,        0, 4'h7, 0, 1, "ldi_end");
        // JMP
        cyc(0, 8'h60, 0, 0, FETCH1,        1, 4'h7, 0, 1, "jmp_t1");
        cyc(0, 8'h00, 0, 0, C_IO | C_J,    2, 4'h0, 0, 1, "jmp_t2");
        cyc(0, 8'h00, 0, 0, 16'h0,         3, 4'h0, 0, 1, "jmp_t3");
        cyc(0, 8'h00, 0, 0, FETCH0,        0, 4'h0, 0, 1, "jmp_end");
        // Reset at T3 of SUB abandons it before FI
        cyc(0, 8'h31, 0, 0, FETCH1,        1, 4'h0, 0, 1, "sub_r_t1");
        cyc(0, 8'h00, 0, 0, C_IO | C_MI,   2, 4'h1, 0, 1, "sub_r_t2");
        cyc(1, 8'hFF, 1, 1, C_RO | C_BI,   3, 4'h1, 0, 1, "sub_r_t3");
        cyc(0, 8'h00, 1, 1, FETCH0,        0, 4'h0, 0, 0, "rst_abandon");
        // HLT holds through bus activity until reset
        cyc(0, 8'hF0, 0, 0, FETCH1,        1, 4'h0, 0, 0, "hlt_t1");
        cyc(0, 8'h00, 1, 1, C_HLT,         2, 4'h0, 0, 0, "hlt_t2");
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            b = 8'(i * 37 + 1);
            cyc(0, b, b[0], b[1], C_HLT,   2, 4'h0, 0, 0, "hlt_hold");
        end
        cyc(1, 8'hFF, 1, 1, C_HLT,         2, 4'h0, 0, 0, "hlt_rst_cyc");
        cyc(0, 8'h00, 0, 0, FETCH0,        0, 4'h0, 0, 0, "hlt_exit");
        cyc(0, 8'h00, 0, 0, FETCH1,        1, 4'h0, 0, 0, "post_hlt_t1");

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left unchecked, want 0", sb_q.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: STEPS, 5, number of microsteps per instruction (T0..T4); the step counter SHALL be 3 bits wide.
REQ-002 clk  input  1  control clock; all state updates on rising edge; system drives it with the inverse phase of the datapath clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 bus_in  input  8  main bus value, sampled for instruction load.
REQ-005 cf_in, zf_in  input  1 each  ALU carry and zero results, sampled for the flags register.
REQ-006 ir_operand  output  4  IR[3:0], driven onto bus bits [3:0] by an external tri-state buffer when IO=1; bits [7:4] driven 0.
REQ-007 HLT, MI, RI, RO, IO, II, AI, AO, EO, SU, BI, OI, CE, CO, J, FI  output  1 each  control word, active-high.
REQ-008 step  output  3  current microstep, for debug LEDs.
REQ-009 carry_flag, zero_flag  output  1 each  flags register contents.

Function
REQ-010 State: IR (8 b), step counter (3 b), flags register (2 b), halted bit (1 b).
REQ-011 Control word SHALL be combinational from IR[7:4], step, carry_flag, zero_flag; no output register, zero-cycle latency from a state change.
REQ-012 T0 SHALL assert CO, MI; T1 SHALL assert RO, II, CE, for every opcode.
REQ-013 T2..T4 by opcode IR[7:4]:
- 0x0 NOP: none.
- 0x1 LDA: T2 IO MI; T3 RO AI.
- 0x2 ADD: T2 IO MI; T3 RO BI; T4 EO AI FI.
- 0x3 SUB: T2 IO MI; T3 RO BI; T4 EO AI SU FI.
- 0x4 STA: T2 IO MI; T3 AO RI.
- 0x5 LDI: T2 IO AI.
- 0x6 JMP: T2 IO J.
- 0x7 JC: T2 IO, plus J only if carry_flag=1.
- 0x8 JZ: T2 IO, plus J only if zero_flag=1.
- 0xE OUT: T2 AO OI.
- 0xF HLT: T2 HLT.
- 0x9-0xD: none (treated as NOP).
REQ-014 On a rising edge with II=1, IR SHALL load bus_in.
REQ-015 On a rising edge with FI=1, carry_flag SHALL load cf_in and zero_flag SHALL load zf_in; otherwise the flags hold.
REQ-016 Step advance: step increments by 1 each edge; from STEPS-1 it SHALL wrap to 0.
REQ-017 Early end: when step>=2 and the decoded control word is all zero, step SHALL go to 0 on the next edge; the empty step still costs one cycle.
REQ-018 Halt: on an edge where HLT=1, halted SHALL set; while halted, step, IR and flags SHALL freeze, and HLT SHALL remain asserted, all other controls 0.
REQ-019 The only exit from halt SHALL be rst.
REQ-020 Conditional jump with the flag clear SHALL still take T2 with IO only, then end early at T3 per REQ-017.
REQ-021 Exactly one opcode row is active per cycle; no two bus-driving outputs (CO, RO, IO, AO, EO) SHALL be asserted together.

Reset
REQ-022 On a rising edge with rst=1: IR=0x00, step=0, flags=0, halted=0; rst SHALL override II, FI and halt in the same cycle.
REQ-023 With rst released, outputs SHALL be: CO=MI=1, all other controls 0, step=0, ir_operand=0.
REQ-024 Reset asserted mid-instruction SHALL abandon the instruction; the next cycle after release begins at T0.

Verification
REQ-025 Reset, then idle: CO=MI=1, other controls 0, step=0, IR=0, flags=0.
REQ-026 bus_in=0x1E during T1 -> IR=0x1E, ir_operand=0xE.
- T2: IO, MI.
- T3: RO, AI.
- T4: no controls; step returns to 0 next edge.
REQ-027 ADD with cf_in=1, zf_in=0 at T4 -> carry_flag=1, zero_flag=0 after the edge.
- Subsequent JC (0x7x): J=1 at T2.
- JZ (0x8x): J=0 at T2, and step 3 -> 0.
REQ-028 IR=0xF0 at T2 -> HLT=1 and step frozen at 2 for 20 cycles with bus_in toggling; rst pulse -> step=0, HLT=0.
REQ-029 rst asserted at T3 of SUB (FI due at T4) -> flags unchanged at 0, IR=0, step=0 after release.
REQ-030 Fetch of opcode 0xB -> T2 has no controls and the instruction completes in 3 cycles total.
